// File: rtl/sha_req_arbiter.sv
// sha_req_arbiter: round-robin front end sharing one sha_algo core.
// Define SHA_ARB_WATCHDOG_EN to add the WAIT_HASH watchdog.
module sha_req_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = $clog2(NUM_REQ)
) (
  input  logic                   clk_p,
  input  logic                   rst_n_p,
  input  logic [NUM_REQ*512-1:0] req_msg_p,
  input  logic [NUM_REQ-1:0]     req_msg_valid_p,
  output logic [NUM_REQ-1:0]     req_msg_rdy_p,
  output logic [255:0]           req_hash_p,
  output logic [NUM_REQ-1:0]     req_hash_valid_p,
  input  logic [NUM_REQ-1:0]     req_hash_rdy_p,
  output logic [511:0]           core_msg_p,
  output logic                   core_msg_valid_p,
  input  logic                   core_msg_rdy_p,
  input  logic [255:0]           core_hash_p,
  input  logic                   core_hash_valid_p,
  output logic                   core_hash_rdy_p,
  output logic [IDW-1:0]         grant_id_p,
  output logic                   busy_p,
  output logic                   timeout_err_p
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_HASH,
    RETURN
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [IDW-1:0] rr_q;
  logic [IDW-1:0] rr_d;
  logic [IDW-1:0] grant_q;
  logic [IDW-1:0] grant_d;
  logic [511:0]   msg_q;
  logic [255:0]   hash_q;

  logic           sel_found;
  logic [IDW-1:0] sel_idx;
  logic [IDW:0]   cand;
  logic [511:0]   sel_msg;
  logic           msg_ld;
  logic           hash_ld;
  logic           expire;
  logic           wd_hit;

  // Pick the first valid requester at or after rr_q, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_q} + (IDW+1)'(i);
      if (cand >= (IDW+1)'(NUM_REQ))
        cand = cand - (IDW+1)'(NUM_REQ);
      if (!sel_found && req_msg_valid_p[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  assign sel_msg = req_msg_p[sel_idx*512 +: 512];

  // Next-state and handshake outputs for the single in-flight message.
  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    grant_d          = grant_q;
    msg_ld           = 1'b0;
    hash_ld          = 1'b0;
    expire           = 1'b0;
    req_msg_rdy_p    = '0;
    req_hash_valid_p = '0;
    core_msg_valid_p = 1'b0;
    core_hash_rdy_p  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sel_found && rst_n_p) begin
          req_msg_rdy_p[sel_idx] = 1'b1;
          msg_ld  = 1'b1;
          grant_d = sel_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        core_msg_valid_p = 1'b1;
        if (core_msg_rdy_p)
          state_d = WAIT_HASH;
      end
      WAIT_HASH: begin
        core_hash_rdy_p = 1'b1;
        if (core_hash_valid_p) begin
          hash_ld = 1'b1;
          state_d = RETURN;
        end else if (wd_hit) begin
          expire  = 1'b1;
          state_d = RETURN;
        end
      end
      RETURN: begin
        req_hash_valid_p[grant_q] = 1'b1;
        if (req_hash_rdy_p[grant_q]) begin
          state_d = IDLE;
          if (grant_q == IDW'(NUM_REQ-1))
            rr_d = '0;
          else
            rr_d = grant_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, pointer and grant registers.
  always_ff @(posedge clk_p or negedge rst_n_p) begin
    if (!rst_n_p) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
    end
  end

  // Message and hash holding registers; a timeout returns a zero hash.
  always_ff @(posedge clk_p or negedge rst_n_p) begin
    if (!rst_n_p) begin
      msg_q  <= '0;
      hash_q <= '0;
    end else begin
      if (msg_ld)
        msg_q <= sel_msg;
      if (hash_ld)
        hash_q <= core_hash_p;
      else if (expire)
        hash_q <= '0;
    end
  end

`ifdef SHA_ARB_WATCHDOG_EN
  logic [15:0] wd_q;
  logic        to_q;

  assign wd_hit = (wd_q == 16'(TIMEOUT_CYCLES-1));

  // Count WAIT_HASH cycles, cleared as the core accepts the message.
  always_ff @(posedge clk_p or negedge rst_n_p) begin
    if (!rst_n_p)
      wd_q <= '0;
    else if (state_q == SEND && core_msg_rdy_p)
      wd_q <= '0;
    else if (state_q == WAIT_HASH)
      wd_q <= wd_q + 16'd1;
  end

  // One-cycle error pulse on the expiry transition.
  always_ff @(posedge clk_p or negedge rst_n_p) begin
    if (!rst_n_p)
      to_q <= 1'b0;
    else
      to_q <= expire;
  end

  assign timeout_err_p = to_q;
`else
  logic cfg_unused;

  assign wd_hit        = 1'b0;
  assign timeout_err_p = 1'b0;
  assign cfg_unused    = ^{expire, 16'(TIMEOUT_CYCLES)};
`endif

  assign core_msg_p = msg_q;
  assign req_hash_p = (state_q == RETURN) ? hash_q : '0;
  assign grant_id_p = grant_q;
  assign busy_p     = (state_q != IDLE);

endmodule

// File: tb/tb_sha_req_arbiter.sv
// tb_sha_req_arbiter: scoreboard bench for sha_req_arbiter.
// Watchdog scenario runs when SHA_ARB_WATCHDOG_EN is defined.
module tb_sha_req_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N*512-1:0] req_msg;
  logic [N-1:0]   req_msg_valid = '0;
  logic [N-1:0]   req_msg_rdy;
  logic [255:0]   req_hash;
  logic [N-1:0]   req_hash_valid;
  logic [N-1:0]   req_hash_rdy = '1;
  logic [511:0]   core_msg;
  logic           core_msg_valid;
  logic           core_msg_rdy;
  logic [255:0]   core_hash;
  logic           core_hash_valid;
  logic           core_hash_rdy;
  logic [1:0]     grant_id;
  logic           busy;
  logic           timeout_err;

  logic [511:0]   m [N];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int             sb_id [$];
  logic [255:0]   sb_hash [$];
  int             grant_cyc [$];
  logic [N-1:0]   keep_req = '0;
  bit             zero_hash_mode = 1'b0;

  int             last_grant;
  bit             last_hs;
  logic [N-1:0]   last_rdy;
  logic [N-1:0]   last_hv;
  logic [255:0]   last_hash;
  logic           last_cmv;
  logic [511:0]   last_cm;
  logic           last_chr;
  logic           last_to;
  logic           last_busy;

  int             core_stall = 0;
  int             core_lat = 0;
  bit             core_mute = 1'b0;

  always #5 clk = ~clk;

  always_comb begin
    req_msg = '0;
    for (int i = 0; i < N; i++)
      req_msg[i*512 +: 512] = m[i];
  end

  sha_req_arbiter #(
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_p(clk),
    .rst_n_p(rst_n),
    .req_msg_p(req_msg),
    .req_msg_valid_p(req_msg_valid),
    .req_msg_rdy_p(req_msg_rdy),
    .req_hash_p(req_hash),
    .req_hash_valid_p(req_hash_valid),
    .req_hash_rdy_p(req_hash_rdy),
    .core_msg_p(core_msg),
    .core_msg_valid_p(core_msg_valid),
    .core_msg_rdy_p(core_msg_rdy),
    .core_hash_p(core_hash),
    .core_hash_valid_p(core_hash_valid),
    .core_hash_rdy_p(core_hash_rdy),
    .grant_id_p(grant_id),
    .busy_p(busy),
    .timeout_err_p(timeout_err)
  );

  function automatic logic [255:0] hfn(input logic [511:0] x);
    return x[511:256] ^ ~x[255:0];
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // sha_algo stand-in: optional accept stall, fixed hash latency
  initial begin
    int           stall_cnt;
    int           lat_cnt;
    logic [511:0] cur;
    stall_cnt = 0;
    lat_cnt = 0;
    cur = '0;
    core_msg_rdy = 1'b0;
    core_hash_valid = 1'b0;
    core_hash = '0;
    forever begin
      @(negedge clk);
      core_msg_rdy = 1'b0;
      core_hash_valid = 1'b0;
      if (!rst_n) begin
        stall_cnt = 0;
        lat_cnt = 0;
      end else if (core_msg_valid) begin
        if (stall_cnt < core_stall) begin
          stall_cnt++;
        end else begin
          core_msg_rdy = 1'b1;
          cur = core_msg;
          stall_cnt = 0;
          lat_cnt = 0;
        end
      end else if (core_hash_rdy && !core_mute) begin
        if (lat_cnt >= core_lat) begin
          core_hash_valid = 1'b1;
          core_hash = hfn(cur);
        end else begin
          lat_cnt++;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: sim time %0t exceeded", $time);
    $fatal(1, "global timeout");
  end

  // one cycle: sample before the edge, scoreboard, react after it
  task automatic step();
    logic [N-1:0] acc;
    int           id;
    logic [255:0] h;
    @(negedge clk);
    #1;
    cyc++;
    acc = req_msg_rdy & req_msg_valid;
    last_grant = -1;
    last_hs = 1'b0;
    last_rdy = req_msg_rdy;
    last_hv = req_hash_valid;
    last_hash = req_hash;
    last_cmv = core_msg_valid;
    last_cm = core_msg;
    last_chr = core_hash_rdy;
    last_to = timeout_err;
    last_busy = busy;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        last_grant = i;
        grant_cyc.push_back(cyc);
        sb_id.push_back(i);
        sb_hash.push_back(zero_hash_mode ? 256'd0 : hfn(m[i]));
      end
    end
    if ((req_hash_valid & req_hash_rdy) != '0) begin
      last_hs = 1'b1;
      total++;
      if (sb_id.size() == 0) begin
        bad++;
        $display("FAIL sb_empty: hash_valid=%b with nothing pending",
                 req_hash_valid);
      end else begin
        id = sb_id.pop_front();
        h = sb_hash.pop_front();
        if (req_hash_valid !== 4'(1 << id) || req_hash !== h) begin
          bad++;
          $display("FAIL sb_hash: valid=%b hash=%h want valid=%b hash=%h",
                   req_hash_valid, req_hash, 4'(1 << id), h);
        end
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (keep_req[i])
          m[i] = rnd512();
        else
          req_msg_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_grant(input int budget, output int id);
    id = -1;
    for (int c = 0; c < budget && id < 0; c++) begin
      step();
      if (last_grant >= 0)
        id = last_grant;
    end
  endtask

  task automatic wait_hash(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      if (last_hs)
        ok = 1'b1;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sb_id.delete();
    sb_hash.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++)
      m[i] = rnd512();
    req_msg_valid = '1;
    @(posedge clk);
    #1;
    total++;
    if ({req_msg_rdy, req_hash_valid, core_msg_valid, core_hash_rdy,
         busy, timeout_err, grant_id} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: rdy=%b hv=%b cmv=%b chr=%b busy=%b to=%b gid=%0d want all 0",
               req_msg_rdy, req_hash_valid, core_msg_valid, core_hash_rdy,
               busy, timeout_err, grant_id);
    end
    total++;
    if (req_hash !== '0 || core_msg !== '0) begin
      bad++;
      $display("FAIL reset_data: req_hash=%h core_msg_nonzero=%b want 0",
               req_hash, |core_msg);
    end
    req_msg_valid = '0;
    apply_reset();
  endtask

  task automatic test_single_req2();
    int id;
    bit ok;
    core_lat = 64;
    req_msg_valid = 4'b0100;
    wait_grant(10, id);
    total++;
    if (id != 2 || last_rdy !== 4'b0100) begin
      bad++;
      $display("FAIL single_grant: id=%0d rdy=%b want id=2 rdy=0100", id, last_rdy);
    end
    step();
    total++;
    if (last_busy !== 1'b1 || last_rdy !== '0) begin
      bad++;
      $display("FAIL single_busy: busy=%b rdy=%b want busy=1 rdy=0000",
               last_busy, last_rdy);
    end
    wait_hash(200, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL single_hash: no hash within bound, want one on req 2");
    end
    core_lat = 2;
    m[1] = rnd512();
    m[3] = rnd512();
    req_msg_valid = 4'b1010;
    wait_grant(10, id);
    total++;
    if (id != 3) begin
      bad++;
      $display("FAIL rr_after_2: granted %0d want 3", id);
    end
    wait_hash(30, ok);
    wait_grant(10, id);
    total++;
    if (id != 1) begin
      bad++;
      $display("FAIL rr_wrap: granted %0d want 1", id);
    end
    wait_hash(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rr_wrap_hash: no hash within bound");
    end
  endtask

  task automatic test_round_robin();
    int id;
    int c0;
    int exp_order [5];
    bit ok;
    exp_order = '{0, 1, 2, 3, 0};
    core_lat = 0;
    rst_n = 1'b0;
    keep_req = '1;
    req_msg_valid = '1;
    apply_reset();
    grant_cyc.delete();
    for (int g = 0; g < 5; g++) begin
      wait_grant(20, id);
      total++;
      if (id != exp_order[g]) begin
        bad++;
        $display("FAIL rr_order[%0d]: granted %0d want %0d", g, id, exp_order[g]);
      end
      if (g > 0) begin
        c0 = grant_cyc[g] - grant_cyc[g-1];
        total++;
        if (c0 != 4) begin
          bad++;
          $display("FAIL rr_gap[%0d]: spacing %0d want 4", g, c0);
        end
      end
    end
    keep_req = '0;
    req_msg_valid = '0;
    wait_hash(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rr_drain: no hash within bound");
    end
  endtask

  task automatic test_hash_hold();
    int           id;
    bit           ok;
    logic [255:0] exp_h;
    core_lat = 3;
    req_hash_rdy = 4'b1101;
    m[1] = rnd512();
    exp_h = hfn(m[1]);
    req_msg_valid = 4'b0010;
    wait_grant(10, id);
    total++;
    if (id != 1) begin
      bad++;
      $display("FAIL hold_grant: granted %0d want 1", id);
    end
    for (int c = 0; c < 20 && last_hv == '0; c++)
      step();
    m[0] = rnd512();
    req_msg_valid = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      step();
      total++;
      if (last_hv !== 4'b0010 || last_hash !== exp_h || last_rdy !== '0) begin
        bad++;
        $display("FAIL hold_c%0d: hv=%b hash=%h rdy=%b want hv=0010 hash=%h rdy=0000",
                 c, last_hv, last_hash, last_rdy, exp_h);
      end
    end
    req_hash_rdy = '1;
    step();
    total++;
    if (!last_hs || last_grant != -1) begin
      bad++;
      $display("FAIL hold_release: hs=%b grant=%0d want hs=1 grant=-1",
               last_hs, last_grant);
    end
    wait_grant(10, id);
    total++;
    if (id != 0) begin
      bad++;
      $display("FAIL hold_next: granted %0d want 0", id);
    end
    wait_hash(30, ok);
  endtask

  task automatic test_send_stall();
    int           id;
    bit           ok;
    logic [511:0] exp_m;
    core_lat = 1;
    core_stall = 10;
    m[0] = rnd512();
    exp_m = m[0];
    req_msg_valid = 4'b0001;
    wait_grant(10, id);
    total++;
    if (id != 0) begin
      bad++;
      $display("FAIL stall_grant: granted %0d want 0", id);
    end
    for (int c = 0; c < 10; c++) begin
      step();
      total++;
      if (last_cmv !== 1'b1 || last_cm !== exp_m) begin
        bad++;
        $display("FAIL stall_c%0d: core_msg_valid=%b msg_match=%b want 1 1",
                 c, last_cmv, last_cm === exp_m);
      end
    end
    core_stall = 0;
    wait_hash(30, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL stall_hash: no hash within bound");
    end
  endtask

  task automatic test_reset_mid();
    int id;
    bit ok;
    core_mute = 1'b1;
    core_lat = 2;
    m[2] = rnd512();
    req_msg_valid = 4'b0100;
    wait_grant(10, id);
    for (int c = 0; c < 10 && !last_chr; c++)
      step();
    total++;
    if (last_chr !== 1'b1) begin
      bad++;
      $display("FAIL mid_wait: core_hash_rdy=%b want 1 before reset", last_chr);
    end
    for (int i = 0; i < N; i++)
      m[i] = rnd512();
    req_msg_valid = '1;
    rst_n = 1'b0;
    sb_id.delete();
    sb_hash.delete();
    #1;
    total++;
    if ({req_msg_rdy, req_hash_valid, core_msg_valid, core_hash_rdy,
         busy, timeout_err, grant_id} !== '0 ||
        req_hash !== '0 || core_msg !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: rdy=%b hv=%b cmv=%b chr=%b busy=%b gid=%0d want all 0",
               req_msg_rdy, req_hash_valid, core_msg_valid, core_hash_rdy,
               busy, grant_id);
    end
    repeat (2) @(posedge clk);
    #1;
    core_mute = 1'b0;
    rst_n = 1'b1;
    wait_grant(10, id);
    total++;
    if (id != 0 || last_busy !== 1'b0) begin
      bad++;
      $display("FAIL mid_regrant: granted %0d busy=%b want 0 busy=0", id, last_busy);
    end
    for (int k = 0; k < 4; k++)
      wait_hash(30, ok);
    total++;
    if (!ok || sb_id.size() != 0) begin
      bad++;
      $display("FAIL mid_drain: ok=%b pending=%0d want 1 0", ok, sb_id.size());
    end
  endtask

`ifdef SHA_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int id;
    int waits;
    core_mute = 1'b1;
    zero_hash_mode = 1'b1;
    m[1] = rnd512();
    req_msg_valid = 4'b0010;
    wait_grant(10, id);
    waits = 0;
    for (int c = 0; c < 100 && last_hv == '0; c++) begin
      step();
      if (last_chr)
        waits++;
    end
    total++;
    if (waits != 16 || last_to !== 1'b1 || !last_hs) begin
      bad++;
      $display("FAIL wd_expire: waits=%0d to=%b hs=%b want 16 1 1",
               waits, last_to, last_hs);
    end
    step();
    total++;
    if (last_to !== 1'b0) begin
      bad++;
      $display("FAIL wd_pulse: timeout_err=%b want 0 one cycle later", last_to);
    end
    zero_hash_mode = 1'b0;
    core_mute = 1'b0;
  endtask
`else
  task automatic test_watchdog();
    int id;
    int errs;
    core_mute = 1'b1;
    m[1] = rnd512();
    req_msg_valid = 4'b0010;
    wait_grant(10, id);
    step();
    errs = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (last_chr !== 1'b1 || last_to !== 1'b0 || last_hv !== '0)
        errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL nowd_wait: %0d bad cycles want 0 (still waiting, no error)", errs);
    end
    core_mute = 1'b0;
    apply_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single_req2();
    test_round_robin();
    test_hash_hold();
    test_send_stall();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sha_req_arbiter.md
SHA_REQ_ARBITER -- requirements
Module: sha_req_arbiter

Interface
REQ-001 Parameter NUM_REQ SHALL be: default 4, legal range 2..8, number of requesters sharing one sha_algo core.
REQ-002 Parameter TIMEOUT_CYCLES SHALL be: default 1024, legal range 16..65535, watchdog limit while waiting for a core hash.
REQ-003 Parameter IDW SHALL be derived, not overridable, as $clog2(NUM_REQ).
REQ-004 Port clk_p SHALL be: input, 1, the single clock; all state changes on its rising edge.
REQ-005 Port rst_n_p SHALL be: input, 1, asynchronous active-low reset.
REQ-006 Port req_msg_p SHALL be: input, NUM_REQ*512, requester i message at [i*512 +: 512].
REQ-007 Port req_msg_valid_p SHALL be: input, NUM_REQ, per-requester message valid.
REQ-008 Port req_msg_rdy_p SHALL be: output, NUM_REQ, per-requester message accept.
REQ-009 Port req_hash_p SHALL be: output, 256, returned hash, shared by all requesters.
REQ-010 Port req_hash_valid_p SHALL be: output, NUM_REQ, per-requester hash valid, at most one bit set.
REQ-011 Port req_hash_rdy_p SHALL be: input, NUM_REQ, per-requester hash accept.
REQ-012 Port core_msg_p SHALL be: output, 512, message to sha_algo.
REQ-013 Port core_msg_valid_p SHALL be: output, 1, message valid to sha_algo.
REQ-014 Port core_msg_rdy_p SHALL be: input, 1, message ready from sha_algo.
REQ-015 Port core_hash_p SHALL be: input, 256, hash from sha_algo.
REQ-016 Port core_hash_valid_p SHALL be: input, 1, hash valid from sha_algo.
REQ-017 Port core_hash_rdy_p SHALL be: output, 1, hash ready to sha_algo.
REQ-018 Port grant_id_p SHALL be: output, IDW, index of the currently owning requester.
REQ-019 Port busy_p SHALL be: output, 1, high in any state other than IDLE.
REQ-020 Port timeout_err_p SHALL be: output, 1, one-cycle pulse on watchdog expiry.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, SEND, WAIT_HASH and RETURN, with one message in flight.
REQ-022 In IDLE with any req_msg_valid_p bit set, the arbiter SHALL select the first set bit at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-023 In that same IDLE cycle, req_msg_rdy_p SHALL be one-hot at the selected index (combinational from valid), the message SHALL be latched, grant_id_p SHALL be loaded and the FSM SHALL go to SEND.
REQ-024 In any state other than IDLE, req_msg_rdy_p SHALL be all-zero, and requests arriving then SHALL wait and be neither dropped nor reordered.
REQ-025 In SEND, core_msg_valid_p SHALL be 1 and core_msg_p SHALL equal the latched message; on core_msg_rdy_p=1 the FSM SHALL go to WAIT_HASH.
REQ-026 In WAIT_HASH, core_hash_rdy_p SHALL be 1 (0 elsewhere); on core_hash_valid_p=1, core_hash_p SHALL be latched and the FSM SHALL go to RETURN.
REQ-027 In RETURN, req_hash_valid_p[grant_id_p] SHALL be 1 and req_hash_p SHALL equal the latched hash; both SHALL hold stable until req_hash_rdy_p[grant_id_p]=1.
REQ-028 On that RETURN handshake the FSM SHALL go to IDLE and set rr_ptr to (grant_id_p+1) mod NUM_REQ.
REQ-029 req_hash_rdy_p bits other than grant_id_p SHALL be ignored.
REQ-030 A new grant SHALL not occur in the same cycle as the RETURN handshake; minimum spacing between grants SHALL be 4 cycles.
REQ-031 req_hash_p SHALL be 0 whenever no req_hash_valid_p bit is set.

Reset
REQ-032 Assertion of rst_n_p low SHALL immediately force: state IDLE, rr_ptr 0, grant_id_p 0, latched message and hash 0, watchdog 0.
REQ-033 During reset, every output SHALL be 0.
REQ-034 Reset SHALL be allowed mid-transaction, and the in-flight message SHALL be discarded without a hash returned.
REQ-035 Deassertion of rst_n_p SHALL be synchronised to clk_p by the integrator, not inside this block.

Configuration
REQ-036 With macro SHA_ARB_WATCHDOG_EN defined, a 16-bit counter SHALL clear on entry to WAIT_HASH and increment each WAIT_HASH cycle.
REQ-037 With SHA_ARB_WATCHDOG_EN defined, on the count reaching TIMEOUT_CYCLES with no hash, timeout_err_p SHALL pulse 1 cycle, the latched hash SHALL be set to 0 and the FSM SHALL go to RETURN.
REQ-038 With SHA_ARB_WATCHDOG_EN defined, a core_hash_valid_p in the expiry cycle SHALL take priority, with the hash latched and no error.
REQ-039 Without SHA_ARB_WATCHDOG_EN, no counter SHALL exist, timeout_err_p SHALL be tied 0 and WAIT_HASH SHALL wait indefinitely.

Verification
REQ-040 The bench SHALL cover: single request on req 2 with core ready and hash after 64 cycles -> rdy[2] pulse, hash returned on req_hash_valid_p[2], rr_ptr=3.
REQ-041 The bench SHALL cover: all 4 valid continuously from reset -> grant order 0,1,2,3,0; no requester granted twice before the others.
REQ-042 The bench SHALL cover: req_hash_rdy_p[1] held low 20 cycles in RETURN -> req_hash_p and valid stable for all 20 cycles, no new grant.
REQ-043 The bench SHALL cover: core_msg_rdy_p low 10 cycles in SEND -> core_msg_valid_p high and core_msg_p unchanged throughout.
REQ-044 The bench SHALL cover: rst_n_p low during WAIT_HASH -> all outputs 0 same cycle, IDLE after release, the next request granted from index 0.
REQ-045 The bench SHALL cover, with SHA_ARB_WATCHDOG_EN and TIMEOUT_CYCLES=16: core never returns a hash -> timeout_err_p pulse after 16 WAIT_HASH cycles and a zero hash returned to the requester.
